// File: rtl/uart_rx_block_ctrl.sv
// Packs UART receive bytes into 128-bit AES blocks with keep/last marking,
// flushing partial blocks on line idle or timeout and discarding errored messages.
module uart_rx_block_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd0
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         En,
  input  logic         drop_on_error,
  input  logic [7:0]   s_tdata,
  input  logic         s_tvalid,
  output logic         s_tready,
  input  logic         rx_idle,
  input  logic         rx_frame_error,
  input  logic         rx_parity_error,
  input  logic         rx_overrun_error,
  output logic [127:0] m_tdata,
  output logic [15:0]  m_tkeep,
  output logic         m_tlast,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic         drop_pulse,
  output logic [7:0]   drop_cnt,
  output logic [7:0]   err_cnt
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILL    = 2'd1,
    OUT     = 2'd2,
    DISCARD = 2'd3
  } state_e;

  state_e       state_q;
  logic [4:0]   cnt_q, cnt_d;
  logic [127:0] buf_q, buf_d;
  logic         msg_open_q;
  logic         err_flag_q;
  logic [31:0]  tmr_q;
  logic [127:0] m_tdata_q;
  logic [15:0]  m_tkeep_q;
  logic         m_tlast_q;
  logic         m_tvalid_q;
  logic         drop_pulse_q;
  logic [7:0]   drop_cnt_q;
  logic [7:0]   err_cnt_q;

  logic         byte_acc_s;
  logic         err_any_s;
  logic         err_set_s;
  logic         tmo_s;
  logic         flush_s;

  assign s_tready   = En & (state_q != OUT);
  assign m_tdata    = m_tdata_q;
  assign m_tkeep    = m_tkeep_q;
  assign m_tlast    = m_tlast_q;
  assign m_tvalid   = m_tvalid_q;
  assign drop_pulse = drop_pulse_q;
  assign drop_cnt   = drop_cnt_q;
  assign err_cnt    = err_cnt_q;

  // Event decode and the buffer/count as they would look after this cycle's byte.
  always_comb begin
    byte_acc_s = s_tvalid & s_tready;
    err_any_s  = rx_frame_error | rx_parity_error | rx_overrun_error;
    err_set_s  = err_any_s & drop_on_error;
    if (TIMEOUT_CYCLES != 32'd0) begin
      tmo_s = (state_q == FILL) && (cnt_q != 5'd0) && (tmr_q == TIMEOUT_CYCLES - 32'd1);
    end else begin
      tmo_s = 1'b0;
    end
    flush_s = rx_idle | tmo_s;
    if (byte_acc_s) begin
      // The buffer is zero beyond cnt, so OR-ing in the shifted byte both places it and pads.
      buf_d = buf_q | ({s_tdata, 120'd0} >> {cnt_q, 3'b000});
      cnt_d = cnt_q + 5'd1;
    end else begin
      buf_d = buf_q;
      cnt_d = cnt_q;
    end
  end

  // Block sequencing FSM with registered stream outputs and counters.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= EMPTY;
      cnt_q        <= 5'd0;
      buf_q        <= 128'd0;
      msg_open_q   <= 1'b0;
      err_flag_q   <= 1'b0;
      tmr_q        <= 32'd0;
      m_tdata_q    <= 128'd0;
      m_tkeep_q    <= 16'd0;
      m_tlast_q    <= 1'b0;
      m_tvalid_q   <= 1'b0;
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= 8'd0;
      err_cnt_q    <= 8'd0;
    end else begin
      drop_pulse_q <= 1'b0;
      if (err_any_s && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
      if (!En) begin
        state_q    <= EMPTY;
        cnt_q      <= 5'd0;
        buf_q      <= 128'd0;
        msg_open_q <= 1'b0;
        err_flag_q <= 1'b0;
        tmr_q      <= 32'd0;
        m_tvalid_q <= 1'b0;
      end else begin
        if (err_set_s) begin
          err_flag_q <= 1'b1;
        end
        if (byte_acc_s) begin
          tmr_q <= 32'd0;
        end else if ((state_q == FILL) && (cnt_q != 5'd0)) begin
          tmr_q <= tmr_q + 32'd1;
        end else begin
          tmr_q <= 32'd0;
        end
        case (state_q)
          EMPTY, FILL: begin
            if (err_flag_q || err_set_s) begin
              state_q <= DISCARD;
              cnt_q   <= 5'd0;
              buf_q   <= 128'd0;
            end else if (cnt_d == 5'd16) begin
              state_q    <= OUT;
              m_tvalid_q <= 1'b1;
              m_tdata_q  <= buf_d;
              m_tkeep_q  <= 16'hFFFF;
              m_tlast_q  <= flush_s;
              msg_open_q <= 1'b1;
              cnt_q      <= 5'd0;
              buf_q      <= 128'd0;
            end else if (flush_s && (cnt_d != 5'd0)) begin
              state_q    <= OUT;
              m_tvalid_q <= 1'b1;
              m_tdata_q  <= buf_d;
              m_tkeep_q  <= ~(16'hFFFF >> cnt_d);
              m_tlast_q  <= 1'b1;
              msg_open_q <= 1'b1;
              cnt_q      <= 5'd0;
              buf_q      <= 128'd0;
            end else if (flush_s && msg_open_q) begin
              // Message ended exactly on a block boundary: close it with an empty block.
              state_q    <= OUT;
              m_tvalid_q <= 1'b1;
              m_tdata_q  <= 128'd0;
              m_tkeep_q  <= 16'd0;
              m_tlast_q  <= 1'b1;
            end else begin
              cnt_q   <= cnt_d;
              buf_q   <= buf_d;
              state_q <= ((cnt_d != 5'd0) || msg_open_q) ? FILL : EMPTY;
            end
          end
          OUT: begin
            if (m_tready) begin
              m_tvalid_q <= 1'b0;
              if (m_tlast_q) begin
                msg_open_q <= 1'b0;
                state_q    <= EMPTY;
              end else if (err_flag_q || err_set_s) begin
                state_q <= DISCARD;
              end else begin
                state_q <= FILL;
              end
            end
          end
          DISCARD: begin
            if (rx_idle) begin
              drop_pulse_q <= 1'b1;
              if (drop_cnt_q != 8'hFF) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
              end
              err_flag_q <= err_set_s;
              msg_open_q <= 1'b0;
              state_q    <= EMPTY;
            end
          end
          default: begin
            state_q <= EMPTY;
          end
        endcase
      end
    end
  end

endmodule
